// File: rtl/mem_access_wb.sv
// Load/store unit: turns one execute-stage memory request at a time into a
// Wishbone B4 pipelined single-beat cycle. It steers store bytes onto the
// lanes, extracts and extends load data, and returns a one-cycle response.
module mem_access_wb #(
  parameter int unsigned TIMEOUT_CYCLES = 64
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_is_store,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wr_data,
  output logic        rsp_valid,
  output logic [31:0] rsp_data,
  output logic        rsp_misaligned,
  output logic        rsp_bus_err,
  output logic        busy,
  output logic        wb_cyc,
  output logic        wb_stb,
  output logic        wb_wr_en,
  output logic [31:0] wb_addr,
  output logic [31:0] wb_wr_data,
  output logic [3:0]  wb_wr_sel,
  input  logic        wb_ack,
  input  logic        wb_stall,
  input  logic [31:0] wb_rd_data
);

  localparam int unsigned CNT_W = 32;
  localparam bit TMO_EN = (TIMEOUT_CYCLES != 0);
  // Last counter value before the timeout fires; unused when TMO_EN is 0.
  localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_WAIT = 2'd2,
    S_RESP = 2'd3
  } state_t;

  state_t           state;
  logic             is_store_q;
  logic [2:0]       funct3_q;
  logic [1:0]       lane_q;
  logic [CNT_W-1:0] tmo_cnt;

  logic             req_illegal_c;
  logic [3:0]       st_sel_c;
  logic [31:0]      st_data_c;
  logic [7:0]       ld_byte_c;
  logic [15:0]      ld_half_c;
  logic [31:0]      ld_data_c;
  logic             timeout_hit_c;

  // Ready is gated by reset so nothing is accepted while held in reset.
  assign req_ready = (state == S_IDLE) && rst_n;

  // Alignment and funct3 legality of the incoming request.
  always_comb begin
    req_illegal_c = 1'b0;
    if (req_is_store) begin
      case (req_funct3)
        3'b000:  req_illegal_c = 1'b0;
        3'b001:  req_illegal_c = req_addr[0];
        3'b010:  req_illegal_c = (req_addr[1:0] != 2'b00);
        default: req_illegal_c = 1'b1;
      endcase
    end else begin
      case (req_funct3)
        3'b000, 3'b100: req_illegal_c = 1'b0;
        3'b001, 3'b101: req_illegal_c = req_addr[0];
        3'b010:         req_illegal_c = (req_addr[1:0] != 2'b00);
        default:        req_illegal_c = 1'b1;
      endcase
    end
  end

  // Byte-lane steering of store data; loads read the whole word.
  always_comb begin
    st_sel_c  = 4'b1111;
    st_data_c = 32'h0;
    if (req_is_store) begin
      case (req_funct3)
        3'b000: begin
          st_sel_c  = 4'b0001 << req_addr[1:0];
          st_data_c = {4{req_wr_data[7:0]}};
        end
        3'b001: begin
          st_sel_c  = 4'b0011 << {req_addr[1], 1'b0};
          st_data_c = {2{req_wr_data[15:0]}};
        end
        default: begin
          st_sel_c  = 4'b1111;
          st_data_c = req_wr_data;
        end
      endcase
    end
  end

  // Load extraction and sign/zero extension from the read data bus.
  always_comb begin
    case (lane_q)
      2'd0:    ld_byte_c = wb_rd_data[7:0];
      2'd1:    ld_byte_c = wb_rd_data[15:8];
      2'd2:    ld_byte_c = wb_rd_data[23:16];
      default: ld_byte_c = wb_rd_data[31:24];
    endcase
    ld_half_c = lane_q[1] ? wb_rd_data[31:16] : wb_rd_data[15:0];
    case (funct3_q)
      3'b000:  ld_data_c = {{24{ld_byte_c[7]}}, ld_byte_c};
      3'b100:  ld_data_c = {24'h0, ld_byte_c};
      3'b001:  ld_data_c = {{16{ld_half_c[15]}}, ld_half_c};
      3'b101:  ld_data_c = {16'h0, ld_half_c};
      default: ld_data_c = wb_rd_data;
    endcase
  end

  // Timeout fires on the edge that closes the TIMEOUT_CYCLES-th cycle of wb_cyc.
  assign timeout_hit_c = TMO_EN && (tmo_cnt == TMO_LAST);

  // Request/response state machine with registered bus and response outputs.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state          <= S_IDLE;
      is_store_q     <= 1'b0;
      funct3_q       <= 3'b000;
      lane_q         <= 2'b00;
      tmo_cnt        <= '0;
      rsp_valid      <= 1'b0;
      rsp_data       <= 32'h0;
      rsp_misaligned <= 1'b0;
      rsp_bus_err    <= 1'b0;
      busy           <= 1'b0;
      wb_cyc         <= 1'b0;
      wb_stb         <= 1'b0;
      wb_wr_en       <= 1'b0;
      wb_addr        <= 32'h0;
      wb_wr_data     <= 32'h0;
      wb_wr_sel      <= 4'h0;
    end else begin
      case (state)
        S_IDLE: begin
          if (req_valid) begin
            is_store_q <= req_is_store;
            funct3_q   <= req_funct3;
            lane_q     <= req_addr[1:0];
            busy       <= 1'b1;
            if (req_illegal_c) begin
              state          <= S_RESP;
              rsp_valid      <= 1'b1;
              rsp_misaligned <= 1'b1;
              rsp_data       <= 32'h0;
            end else begin
              state      <= S_REQ;
              wb_cyc     <= 1'b1;
              wb_stb     <= 1'b1;
              wb_wr_en   <= req_is_store;
              wb_addr    <= {req_addr[31:2], 2'b00};
              wb_wr_sel  <= st_sel_c;
              wb_wr_data <= st_data_c;
              tmo_cnt    <= '0;
            end
          end
        end

        S_REQ, S_WAIT: begin
          // Ack counts in REQ only on the edge the strobe is accepted.
          if (wb_ack && (state == S_WAIT || !wb_stall)) begin
            state     <= S_RESP;
            wb_cyc    <= 1'b0;
            wb_stb    <= 1'b0;
            rsp_valid <= 1'b1;
            rsp_data  <= is_store_q ? 32'h0 : ld_data_c;
          end else if (timeout_hit_c) begin
            state       <= S_RESP;
            wb_cyc      <= 1'b0;
            wb_stb      <= 1'b0;
            rsp_valid   <= 1'b1;
            rsp_bus_err <= 1'b1;
            rsp_data    <= 32'h0;
          end else begin
            tmo_cnt <= tmo_cnt + CNT_W'(1);
            if (state == S_REQ && !wb_stall) begin
              state  <= S_WAIT;
              wb_stb <= 1'b0;
            end
          end
        end

        default: begin
          state          <= S_IDLE;
          busy           <= 1'b0;
          rsp_valid      <= 1'b0;
          rsp_data       <= 32'h0;
          rsp_misaligned <= 1'b0;
          rsp_bus_err    <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_access_wb.sv
// Directed self-checking bench for mem_access_wb with a small Wishbone slave.
module tb_mem_access_wb;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_is_store = 1'b0;
  logic [2:0]  req_funct3 = 3'b000;
  logic [31:0] req_addr = 32'h0;
  logic [31:0] req_wr_data = 32'h0;
  logic        rsp_valid;
  logic [31:0] rsp_data;
  logic        rsp_misaligned;
  logic        rsp_bus_err;
  logic        busy;
  logic        wb_cyc, wb_stb, wb_wr_en;
  logic [31:0] wb_addr, wb_wr_data;
  logic [3:0]  wb_wr_sel;
  logic        wb_ack = 1'b0;
  logic        wb_stall = 1'b0;
  logic [31:0] wb_rd_data = 32'h0;

  int n_cmp = 0;
  int n_fail = 0;

  // Slave configuration, written only by the test tasks.
  int ack_lat = 0;
  bit no_ack = 1'b0;
  int stall_n = 0;
  bit inject_ack = 1'b0;

  // Slave state, owned by the slave processes.
  logic [31:0] mem [0:63];
  bit          mem_inited = 1'b0;
  int          stb_run = 0;
  bit          pend = 1'b0;
  logic [5:0]  pend_idx = 6'd0;

  // Monitor state, owned by the monitor process.
  int          stb_cycles = 0;
  int          cyc_cycles = 0;
  int          rsp_pulses = 0;
  logic [31:0] cap_addr = 32'h0;
  logic [31:0] cap_data = 32'h0;
  logic [3:0]  cap_sel = 4'h0;
  logic        cap_wr_en = 1'b0;

  mem_access_wb #(.TIMEOUT_CYCLES(8)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_is_store(req_is_store),
    .req_funct3(req_funct3), .req_addr(req_addr), .req_wr_data(req_wr_data),
    .rsp_valid(rsp_valid), .rsp_data(rsp_data), .rsp_misaligned(rsp_misaligned),
    .rsp_bus_err(rsp_bus_err), .busy(busy),
    .wb_cyc(wb_cyc), .wb_stb(wb_stb), .wb_wr_en(wb_wr_en), .wb_addr(wb_addr),
    .wb_wr_data(wb_wr_data), .wb_wr_sel(wb_wr_sel),
    .wb_ack(wb_ack), .wb_stall(wb_stall), .wb_rd_data(wb_rd_data)
  );

  always #5 clk = ~clk;

  // Slave drive side: stall, ack and read data change on the falling edge.
  always @(negedge clk) begin
    wb_ack     = 1'b0;
    wb_rd_data = 32'h0;
    wb_stall   = wb_stb && (stb_run < stall_n);
    if (!no_ack && ack_lat == 0 && wb_stb && !wb_stall) begin
      wb_ack     = 1'b1;
      wb_rd_data = mem[wb_addr[7:2]];
    end
    if (!no_ack && ack_lat == 1 && pend) begin
      wb_ack     = 1'b1;
      wb_rd_data = mem[pend_idx];
    end
    if (inject_ack) begin
      wb_ack     = 1'b1;
      wb_rd_data = 32'hBAD0BAD0;
    end
  end

  // Slave sample side: strobe acceptance and byte-enabled memory writes.
  always @(posedge clk) begin
    if (!mem_inited) begin
      for (int i = 0; i < 64; i++) mem[i] = 32'h0;
      mem_inited = 1'b1;
    end
    stb_run  = wb_stb ? stb_run + 1 : 0;
    pend     = wb_stb && !wb_stall;
    pend_idx = wb_addr[7:2];
    if (wb_stb && !wb_stall && wb_wr_en) begin
      for (int b = 0; b < 4; b++)
        if (wb_wr_sel[b]) mem[wb_addr[7:2]][8*b +: 8] = wb_wr_data[8*b +: 8];
    end
  end

  // Bus/response monitor.
  always @(negedge clk) begin
    if (wb_stb) begin
      stb_cycles = stb_cycles + 1;
      cap_addr   = wb_addr;
      cap_data   = wb_wr_data;
      cap_sel    = wb_wr_sel;
      cap_wr_en  = wb_wr_en;
    end
    if (wb_cyc) cyc_cycles = cyc_cycles + 1;
    if (rsp_valid) rsp_pulses = rsp_pulses + 1;
  end

  // Present a request once ready; returns 1 ns after the handshake edge.
  task automatic send(input bit st, input logic [2:0] f3,
                      input logic [31:0] a, input logic [31:0] d);
    int k = 0;
    @(negedge clk);
    while (!req_ready && k < 50) begin
      @(negedge clk);
      k++;
    end
    req_valid    = 1'b1;
    req_is_store = st;
    req_funct3   = f3;
    req_addr     = a;
    req_wr_data  = d;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
  endtask

  // Cycles from the handshake edge to rsp_valid; -1 if it never came.
  task automatic wait_rsp(output int lat);
    lat = -1;
    for (int k = 1; k <= 40; k++) begin
      if (rsp_valid) begin
        lat = k;
        break;
      end
      @(posedge clk);
      #1;
    end
  endtask

  task automatic test_reset;
    repeat (3) @(posedge clk);
    #1;
    n_cmp++; if (req_ready !== 1'b0) begin n_fail++; $display("FAIL reset_ready got %b want 0", req_ready); end
    n_cmp++; if ({busy, wb_cyc, wb_stb, rsp_valid, rsp_bus_err, rsp_misaligned} !== 6'b0) begin
      n_fail++; $display("FAIL reset_ctrl got %b want 000000", {busy, wb_cyc, wb_stb, rsp_valid, rsp_bus_err, rsp_misaligned}); end
    n_cmp++; if ({wb_addr, wb_wr_data, wb_wr_sel, wb_wr_en, rsp_data} !== 101'b0) begin
      n_fail++; $display("FAIL reset_data got addr %h wd %h sel %h data %h want 0", wb_addr, wb_wr_data, wb_wr_sel, rsp_data); end
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    n_cmp++; if (req_ready !== 1'b1) begin n_fail++; $display("FAIL reset_ready_release got %b want 1", req_ready); end
  endtask

  task automatic test_store_word;
    int lat;
    ack_lat = 0;
    send(1'b1, 3'b010, 32'h10, 32'hDEADBEEF);
    n_cmp++; if ({busy, wb_cyc, wb_stb} !== 3'b111) begin n_fail++; $display("FAIL sw_req_phase got %b want 111", {busy, wb_cyc, wb_stb}); end
    wait_rsp(lat);
    n_cmp++; if (lat !== 2) begin n_fail++; $display("FAIL sw_latency got %0d want 2", lat); end
    n_cmp++; if ({cap_addr, cap_sel, cap_wr_en} !== {32'h10, 4'hF, 1'b1}) begin
      n_fail++; $display("FAIL sw_bus got addr %h sel %b we %b want 00000010 1111 1", cap_addr, cap_sel, cap_wr_en); end
    n_cmp++; if (cap_data !== 32'hDEADBEEF) begin n_fail++; $display("FAIL sw_wdata got %h want deadbeef", cap_data); end
    n_cmp++; if ({rsp_data, rsp_misaligned, rsp_bus_err} !== 34'b0) begin
      n_fail++; $display("FAIL sw_rsp got data %h mis %b err %b want 0", rsp_data, rsp_misaligned, rsp_bus_err); end
    @(posedge clk);
    #1;
    n_cmp++; if ({rsp_valid, req_ready, busy} !== 3'b010) begin
      n_fail++; $display("FAIL sw_after got valid/ready/busy %b want 010", {rsp_valid, req_ready, busy}); end
    send(1'b0, 3'b010, 32'h10, 32'h0);
    wait_rsp(lat);
    n_cmp++; if (lat !== 2 || rsp_data !== 32'hDEADBEEF) begin
      n_fail++; $display("FAIL lw_readback got lat %0d data %h want 2 deadbeef", lat, rsp_data); end
    n_cmp++; if ({cap_sel, cap_wr_en, cap_data} !== {4'hF, 1'b0, 32'h0}) begin
      n_fail++; $display("FAIL lw_bus got sel %b we %b wd %h want 1111 0 0", cap_sel, cap_wr_en, cap_data); end
  endtask

  task automatic test_load_extend;
    logic [2:0]  f3 [4];
    logic [31:0] ad [4];
    logic [31:0] ex [4];
    int lat;
    f3[0] = 3'b000; ad[0] = 32'h23; ex[0] = 32'hFFFFFF80;
    f3[1] = 3'b100; ad[1] = 32'h23; ex[1] = 32'h00000080;
    f3[2] = 3'b001; ad[2] = 32'h22; ex[2] = 32'hFFFF80FF;
    f3[3] = 3'b101; ad[3] = 32'h20; ex[3] = 32'h00007F01;
    ack_lat = 0;
    send(1'b1, 3'b010, 32'h20, 32'h80FF7F01);
    wait_rsp(lat);
    ack_lat = 1;
    for (int i = 0; i < 4; i++) begin
      send(1'b0, f3[i], ad[i], 32'h0);
      wait_rsp(lat);
      n_cmp++; if (lat !== 3 || rsp_data !== ex[i] || cap_addr !== 32'h20) begin
        n_fail++; $display("FAIL load_ext_%0d got lat %0d data %h addr %h want 3 %h 00000020", i, lat, rsp_data, cap_addr, ex[i]); end
    end
  endtask

  task automatic test_store_steer;
    int lat;
    ack_lat = 0;
    send(1'b1, 3'b000, 32'h31, 32'h123456AB);
    wait_rsp(lat);
    n_cmp++; if ({cap_addr, cap_sel, cap_data} !== {32'h30, 4'b0010, 32'hABABABAB}) begin
      n_fail++; $display("FAIL sb_steer got addr %h sel %b data %h want 00000030 0010 abababab", cap_addr, cap_sel, cap_data); end
    send(1'b1, 3'b001, 32'h32, 32'hFFFF1234);
    wait_rsp(lat);
    n_cmp++; if ({cap_addr, cap_sel, cap_data} !== {32'h30, 4'b1100, 32'h12341234}) begin
      n_fail++; $display("FAIL sh_steer got addr %h sel %b data %h want 00000030 1100 12341234", cap_addr, cap_sel, cap_data); end
    send(1'b0, 3'b010, 32'h30, 32'h0);
    wait_rsp(lat);
    n_cmp++; if (rsp_data !== 32'h1234AB00) begin n_fail++; $display("FAIL steer_merge got %h want 1234ab00", rsp_data); end
  endtask

  task automatic test_illegal;
    bit          st [4];
    logic [2:0]  f3 [4];
    logic [31:0] ad [4];
    int lat, c0;
    st[0] = 1'b0; f3[0] = 3'b010; ad[0] = 32'h42;
    st[1] = 1'b1; f3[1] = 3'b001; ad[1] = 32'h41;
    st[2] = 1'b0; f3[2] = 3'b011; ad[2] = 32'h40;
    st[3] = 1'b1; f3[3] = 3'b100; ad[3] = 32'h40;
    for (int i = 0; i < 4; i++) begin
      c0 = cyc_cycles;
      send(st[i], f3[i], ad[i], 32'hFFFFFFFF);
      wait_rsp(lat);
      n_cmp++; if (lat !== 1 || {rsp_misaligned, rsp_bus_err} !== 2'b10 || rsp_data !== 32'h0) begin
        n_fail++; $display("FAIL illegal_%0d got lat %0d mis %b err %b data %h want 1 1 0 0", i, lat, rsp_misaligned, rsp_bus_err, rsp_data); end
      @(posedge clk);
      #1;
      n_cmp++; if (cyc_cycles - c0 !== 0 || rsp_valid !== 1'b0) begin
        n_fail++; $display("FAIL illegal_bus_%0d got cyc %0d valid %b want 0 0", i, cyc_cycles - c0, rsp_valid); end
    end
  endtask

  task automatic test_stall;
    int lat, s0;
    ack_lat = 1;
    stall_n = 3;
    s0 = stb_cycles;
    send(1'b0, 3'b010, 32'h10, 32'h0);
    wait_rsp(lat);
    n_cmp++; if (lat !== 6 || rsp_data !== 32'hDEADBEEF) begin
      n_fail++; $display("FAIL stall_rsp got lat %0d data %h want 6 deadbeef", lat, rsp_data); end
    n_cmp++; if (stb_cycles - s0 !== 4) begin n_fail++; $display("FAIL stall_stb got %0d want 4", stb_cycles - s0); end
    stall_n = 0;
  endtask

  task automatic test_timeout;
    int lat, c0;
    no_ack = 1'b1;
    c0 = cyc_cycles;
    send(1'b0, 3'b010, 32'h10, 32'h0);
    wait_rsp(lat);
    n_cmp++; if (lat !== 9 || {rsp_bus_err, rsp_misaligned} !== 2'b10 || rsp_data !== 32'h0) begin
      n_fail++; $display("FAIL timeout_rsp got lat %0d err %b mis %b data %h want 9 1 0 0", lat, rsp_bus_err, rsp_misaligned, rsp_data); end
    n_cmp++; if (cyc_cycles - c0 !== 8) begin n_fail++; $display("FAIL timeout_cyc got %0d want 8", cyc_cycles - c0); end
    @(posedge clk);
    #1;
    n_cmp++; if ({req_ready, rsp_valid, rsp_bus_err} !== 3'b100) begin
      n_fail++; $display("FAIL timeout_after got ready/valid/err %b want 100", {req_ready, rsp_valid, rsp_bus_err}); end
    no_ack = 1'b0;
  endtask

  task automatic test_reset_mid;
    int lat, r0;
    no_ack = 1'b1;
    ack_lat = 1;
    r0 = rsp_pulses;
    send(1'b0, 3'b010, 32'h10, 32'h0);
    @(posedge clk);
    #1;
    n_cmp++; if ({wb_cyc, wb_stb} !== 2'b10) begin n_fail++; $display("FAIL rstmid_wait got cyc/stb %b want 10", {wb_cyc, wb_stb}); end
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    n_cmp++; if ({wb_cyc, wb_stb, busy, req_ready} !== 4'b0000) begin
      n_fail++; $display("FAIL rstmid_drop got cyc/stb/busy/ready %b want 0000", {wb_cyc, wb_stb, busy, req_ready}); end
    rst_n = 1'b1;
    @(negedge clk);
    inject_ack = 1'b1;
    @(negedge clk);
    inject_ack = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    n_cmp++; if (rsp_pulses - r0 !== 0 || busy !== 1'b0) begin
      n_fail++; $display("FAIL rstmid_no_rsp got pulses %0d busy %b want 0 0", rsp_pulses - r0, busy); end
    no_ack = 1'b0;
    send(1'b0, 3'b010, 32'h10, 32'h0);
    wait_rsp(lat);
    n_cmp++; if (lat !== 3 || rsp_data !== 32'hDEADBEEF || rsp_bus_err !== 1'b0) begin
      n_fail++; $display("FAIL rstmid_next got lat %0d data %h err %b want 3 deadbeef 0", lat, rsp_data, rsp_bus_err); end
  endtask

  initial begin
    test_reset();
    test_store_word();
    test_load_extend();
    test_store_steer();
    test_illegal();
    test_stall();
    test_timeout();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
